pipe_stage_chain: RTL and testbench

Parametrised elastic pipeline of DEPTH stages carrying a WIDTH-bit payload, with per-stage valid bits, ready/valid backpressure, bubble collapse and per-stage kill. It replaces the fixed IF/ID/EX/MEM/WB register chain with flat reset and flush wiring. A CPU datapath instantiates it to get stall, flush and occupancy tracking from one block.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_stage_slot.sv | 44 ++++
 rtl/pipe_stage_chain.sv | 127 ++++++++++++
 tb/tb_pipe_stage_chain.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline chain.
// Holds the occupancy width helper, the statistics width and a popcount used for kill accounting.
package pipe_pkg;

  localparam int STAT_W    = 32;
  localparam int MAX_DEPTH = 64;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Callers zero-extend their stage mask to MAX_DEPTH bits before counting.
  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      cnt = cnt + {31'b0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One elastic pipeline slot: a valid bit plus a payload register.
// The payload only reloads when a live entry arrives, so bubbles leave the data untouched.
module pipe_stage_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adv_i,
  input  logic             kill_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A slot that does not advance keeps its entry unless it is killed this cycle.
  always_comb begin
    valid_d = valid_q & ~kill_i;
    data_d  = data_q;
    if (adv_i) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic DEPTH-stage pipeline with ready/valid backpressure, bubble collapse, per-stage kill and occupancy.
// Defining PIPE_CHAIN_STATS_EN adds saturating stall and kill counters (stall_cnt_o, kill_cnt_o).
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int OCC_W = occ_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [WIDTH-1:0]  in_data_i,
  output logic              in_ready_o,
  input  logic [DEPTH-1:0]  flush_i,
  output logic              out_valid_o,
  output logic [WIDTH-1:0]  out_data_o,
  input  logic              out_ready_i,
  output logic [DEPTH-1:0]  stage_valid_o,
`ifdef PIPE_CHAIN_STATS_EN
  output logic [STAT_W-1:0] stall_cnt_o,
  output logic [STAT_W-1:0] kill_cnt_o,
`endif
  output logic [OCC_W-1:0]  occupancy_o
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] killMask;
  logic [DEPTH:0]   rdy;
  logic [WIDTH-1:0] stageData [DEPTH];
  logic             accept;
  logic             fire;
  logic [OCC_W-1:0] killCnt;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign live     = valid & ~flush_i;
  assign killMask = valid & flush_i;

  // A stage is ready when it holds nothing live or the stage after it is ready.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = ~live[k] | rdy[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : gSlot
    logic             inValid;
    logic [WIDTH-1:0] inData;

    if (k == 0) begin : gHead
      assign inValid = in_valid_i;
      assign inData  = in_data_i;
    end else begin : gBody
      assign inValid = live[k-1];
      assign inData  = stageData[k-1];
    end

    pipe_stage_slot #(.WIDTH(WIDTH)) uSlot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .adv_i      (rdy[k]),
      .kill_i     (flush_i[k]),
      .in_valid_i (inValid),
      .in_data_i  (inData),
      .valid_o    (valid[k]),
      .data_o     (stageData[k])
    );
  end

  assign in_ready_o    = rdy[0] & ~rst_i;
  assign accept        = in_valid_i & in_ready_o;
  assign out_valid_o   = live[DEPTH-1] & ~rst_i;
  assign out_data_o    = stageData[DEPTH-1];
  assign fire          = out_valid_o & out_ready_i;
  assign stage_valid_o = valid;

  assign killCnt = OCC_W'(popcount(MAX_DEPTH'(killMask)));

  always_comb begin
    occ_d = occ_q + OCC_W'(accept) - OCC_W'(fire) - killCnt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy_o = occ_q;

`ifdef PIPE_CHAIN_STATS_EN
  logic [STAT_W-1:0] stall_q, stall_d;
  logic [STAT_W-1:0] kill_q, kill_d;
  logic [STAT_W:0]   killSum;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_d = stall_q;
    if (in_valid_i & ~in_ready_o & ~(&stall_q)) begin
      stall_d = stall_q + STAT_W'(1);
    end
    killSum = {1'b0, kill_q} + (STAT_W + 1)'(popcount(MAX_DEPTH'(killMask)));
    kill_d  = killSum[STAT_W] ? '1 : killSum[STAT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      kill_q  <= '0;
    end else begin
      stall_q <= stall_d;
      kill_q  <= kill_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign kill_cnt_o  = kill_q;
`else
  // Without statistics the kill mask only feeds the occupancy update.
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (WIDTH=32, DEPTH=4) with directed, hand-computed vectors.
// The stats counters are exercised only when PIPE_CHAIN_STATS_EN is defined.
module tb_pipe_stage_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int OCC_W = 3;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             in_valid_i = 1'b0;
  logic [WIDTH-1:0] in_data_i = '0;
  logic             in_ready_o;
  logic [DEPTH-1:0] flush_i = '0;
  logic             out_valid_o;
  logic [WIDTH-1:0] out_data_o;
  logic             out_ready_i = 1'b0;
  logic [DEPTH-1:0] stage_valid_o;
  logic [OCC_W-1:0] occupancy_o;
`ifdef PIPE_CHAIN_STATS_EN
  logic [31:0]      stall_cnt_o;
  logic [31:0]      kill_cnt_o;
`endif

  int               checks = 0;
  int               failures = 0;
  logic [WIDTH-1:0] expQ [$];
  bit               done = 1'b0;

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_data_i     (in_data_i),
    .in_ready_o    (in_ready_o),
    .flush_i       (flush_i),
    .out_valid_o   (out_valid_o),
    .out_data_o    (out_data_o),
    .out_ready_i   (out_ready_i),
    .stage_valid_o (stage_valid_o),
`ifdef PIPE_CHAIN_STATS_EN
    .stall_cnt_o   (stall_cnt_o),
    .kill_cnt_o    (kill_cnt_o),
`endif
    .occupancy_o   (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expectOut(input logic [WIDTH-1:0] data);
    expQ.push_back(data);
  endtask

  // Holds the payload until the chain takes it, giving up after a bounded wait.
  task automatic applyStimulus(input logic [WIDTH-1:0] data);
    bit ok;
    ok = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = data;
    for (int n = 0; n < 64 && !ok; n++) begin
      #1;
      ok = in_ready_o;
      tick();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=no_accept required=accept data=0x%0h", data);
    end
  endtask

  task automatic waitDrain(input string name);
    in_valid_i  = 1'b0;
    flush_i     = '0;
    out_ready_i = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (expQ.size() == 0 && occupancy_o == '0) break;
      tick();
    end
    checkOutput({name, "_drain_queue"}, 32'(expQ.size()), 32'd0);
    checkOutput({name, "_drain_occ"}, 32'(occupancy_o), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every output fire and checks the occupancy invariant.
  initial begin
    logic [WIDTH-1:0] expData;
    forever begin
      @(negedge clk_i);
      if (done) break;
      checkOutput("occ_invariant", 32'(occupancy_o), 32'($countones(stage_valid_o)));
      if (out_valid_o && out_ready_i) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output actual=0x%0h required=no_output", out_data_o);
        end else begin
          expData = expQ.pop_front();
          checkOutput("out_data", out_data_o, expData);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset, with an accept attempted while reset is high.
    tick();
    in_valid_i = 1'b1;
    in_data_i  = 32'hBAD0_0BAD;
    out_ready_i = 1'b1;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready_o), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
    tick();
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    #1;
    checkOutput("rst_stage_valid", 32'(stage_valid_o), 32'd0);
    checkOutput("rst_occ", 32'(occupancy_o), 32'd0);

    // 1: stream three entries with the sink always ready.
    $display("[TB] test 1 stream");
    out_ready_i = 1'b1;
    expectOut(32'h11); expectOut(32'h22); expectOut(32'h33);
    in_valid_i = 1'b1;
    in_data_i  = 32'h11;
    #1;
    checkOutput("t1_ready", 32'(in_ready_o), 32'd1);
    tick();
    in_data_i = 32'h22;
    tick();
    in_data_i = 32'h33;
    tick();
    in_valid_i = 1'b0;
    checkOutput("t1_occ_peak", 32'(occupancy_o), 32'd3);
    checkOutput("t1_out_not_yet", 32'(out_valid_o), 32'd0);
    tick();
    checkOutput("t1_out_valid", 32'(out_valid_o), 32'd1);
    checkOutput("t1_out_data", out_data_o, 32'h11);
    checkOutput("t1_occ_hold", 32'(occupancy_o), 32'd3);
    waitDrain("t1");

    // 2: fill against a stalled sink, then release.
    $display("[TB] test 2 backpressure");
    out_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expectOut(WIDTH'(i));
      in_valid_i = 1'b1;
      in_data_i  = WIDTH'(i);
      #1;
      checkOutput("t2_fill_ready", 32'(in_ready_o), 32'd1);
      tick();
    end
    in_data_i = 32'd5;
    #1;
    checkOutput("t2_full_stall", 32'(in_ready_o), 32'd0);
    checkOutput("t2_full_valid", 32'(stage_valid_o), 32'hF);
    checkOutput("t2_full_occ", 32'(occupancy_o), 32'd4);
    tick();
    checkOutput("t2_still_full", 32'(occupancy_o), 32'd4);
    out_ready_i = 1'b1;
    expectOut(32'd5);
    #1;
    checkOutput("t2_release_ready", 32'(in_ready_o), 32'd1);
    tick();
    checkOutput("t2_accept_fire_occ", 32'(occupancy_o), 32'd4);
    expectOut(32'd6);
    applyStimulus(32'd6);
    waitDrain("t2");

    // 3: a lone entry at the output, then bubbles collapse behind it.
    $display("[TB] test 3 bubble collapse");
    out_ready_i = 1'b0;
    expectOut(32'hA0);
    applyStimulus(32'hA0);
    in_valid_i = 1'b0;
    tick(); tick(); tick();
    checkOutput("t3_lone_entry", 32'(stage_valid_o), 32'h8);
    for (int i = 1; i <= 3; i++) begin
      expectOut(32'hA0 + WIDTH'(i));
      applyStimulus(32'hA0 + WIDTH'(i));
    end
    in_valid_i = 1'b0;
    checkOutput("t3_collapsed", 32'(stage_valid_o), 32'hF);
    checkOutput("t3_occ", 32'(occupancy_o), 32'd4);
    checkOutput("t3_head_data", out_data_o, 32'hA0);
    waitDrain("t3");

    // 4: kill stage 1 of a full pipe while a new entry enters.
    $display("[TB] test 4 selective kill");
    out_ready_i = 1'b0;
    applyStimulus(32'hDD);
    applyStimulus(32'hCC);
    applyStimulus(32'hBB);
    applyStimulus(32'hAA);
    expectOut(32'hDD); expectOut(32'hCC); expectOut(32'hAA); expectOut(32'hEE);
    flush_i    = 4'b0010;
    in_valid_i = 1'b1;
    in_data_i  = 32'hEE;
    #1;
    checkOutput("t4_kill_ready", 32'(in_ready_o), 32'd1);
    tick();
    flush_i    = '0;
    in_valid_i = 1'b0;
    checkOutput("t4_occ", 32'(occupancy_o), 32'd4);
    checkOutput("t4_valid", 32'(stage_valid_o), 32'hF);
    waitDrain("t4");

    // Flush every stage while one entry enters.
    $display("[TB] test flush all");
    out_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) applyStimulus(32'h70 + WIDTH'(i));
    flush_i    = 4'b1111;
    in_valid_i = 1'b1;
    in_data_i  = 32'h77;
    expectOut(32'h77);
    #1;
    checkOutput("fa_ready", 32'(in_ready_o), 32'd1);
    tick();
    flush_i    = '0;
    in_valid_i = 1'b0;
    checkOutput("fa_occ", 32'(occupancy_o), 32'd1);
    checkOutput("fa_valid", 32'(stage_valid_o), 32'h1);
    waitDrain("fa");

    // Kill the output stage while the sink is ready.
    $display("[TB] test kill last");
    out_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) applyStimulus(32'h50 + WIDTH'(i));
    in_valid_i = 1'b0;
    expectOut(32'h52); expectOut(32'h53); expectOut(32'h54);
    flush_i     = 4'b1000;
    out_ready_i = 1'b1;
    #1;
    checkOutput("kl_no_fire", 32'(out_valid_o), 32'd0);
    tick();
    flush_i = '0;
    checkOutput("kl_occ", 32'(occupancy_o), 32'd3);
    checkOutput("kl_head", out_data_o, 32'h52);
    waitDrain("kl");

    // 5: reset mid-stream with a held input.
    $display("[TB] test 5 reset mid-stream");
    out_ready_i = 1'b0;
    for (int i = 1; i <= 3; i++) applyStimulus(32'h60 + WIDTH'(i));
    in_valid_i = 1'b0;
    #1;
    checkOutput("t5_occ_before", 32'(occupancy_o), 32'd3);
    rst_i       = 1'b1;
    in_valid_i  = 1'b1;
    in_data_i   = 32'h99;
    out_ready_i = 1'b1;
    #1;
    checkOutput("t5_rst_ready", 32'(in_ready_o), 32'd0);
    checkOutput("t5_rst_out_valid", 32'(out_valid_o), 32'd0);
    tick();
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    checkOutput("t5_valid", 32'(stage_valid_o), 32'd0);
    checkOutput("t5_occ", 32'(occupancy_o), 32'd0);
    checkOutput("t5_out_valid", 32'(out_valid_o), 32'd0);
    tick(); tick();
    checkOutput("t5_not_captured", 32'(occupancy_o), 32'd0);

`ifdef PIPE_CHAIN_STATS_EN
    // 6: five stalled cycles, then a full flush of four entries.
    $display("[TB] test 6 stats");
    checkOutput("t6_stall_reset", stall_cnt_o, 32'd0);
    checkOutput("t6_kill_reset", kill_cnt_o, 32'd0);
    out_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) applyStimulus(32'h80 + WIDTH'(i));
    in_data_i = 32'h85;
    tick(); tick(); tick(); tick(); tick();
    in_valid_i = 1'b0;
    flush_i    = 4'b1111;
    tick();
    flush_i = '0;
    checkOutput("t6_stall_cnt", stall_cnt_o, 32'd5);
    checkOutput("t6_kill_cnt", kill_cnt_o, 32'd4);
    checkOutput("t6_occ", 32'(occupancy_o), 32'd0);
`endif

    tick();
    done = 1'b1;
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
